// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// VgaTimingGen (module vga_timing_gen)
//
// Purpose:
//   Raster timing generator for the VGA path. It produces the current pixel
//   position, the active-video flag, the connector sync pins and the line and
//   frame start strobes. The drawing stage consumes all of these on the same
//   pixel_clock. The default timing is 640x480 @ 60 Hz (800x525 total), with
//   one pixel per clock.
//
// Ports:
//   pixel_clock  in   1   pixel clock, rising edge
//   rst          in   1   asynchronous, active-high reset
//   hPos         out  10  horizontal count, 0..H_TOTAL-1
//   vPos         out  10  vertical count, 0..V_TOTAL-1
//   videoOn      out  1   high inside the visible H_ACTIVE x V_ACTIVE window
//   hsync        out  1   horizontal sync, asserted level = SYNC_POL
//   vsync        out  1   vertical sync, asserted level = SYNC_POL
//   line_start   out  1   one-cycle pulse when hPos==0
//   frame_start  out  1   one-cycle pulse when hPos==0 and vPos==0
//   frame_count  out  16  frames completed since reset
//
// Configuration:
//   VGA_FRAME_COUNT_EN - when defined, frame_count counts frames. When it is
//   undefined, frame_count is tied to zero and no counter logic exists.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        pixel_clock,
  input  logic        rst,
  output logic [9:0]  hPos,
  output logic [9:0]  vPos,
  output logic        videoOn,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  // Counter limits and sync windows. These are pre-sized to the 10-bit
  // counter width so that every compare below is between equal widths.
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       SYNC_ON  = (SYNC_POL != 0);
  localparam logic       SYNC_OFF = !SYNC_ON;

  logic [9:0] hCnt_q, hCnt_d;
  logic [9:0] vCnt_q, vCnt_d;
  logic       hWrap;
  logic       videoOn_q, videoOn_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       lineStart_q, lineStart_d;
  logic       frameStart_q, frameStart_d;

  // Next-position logic. A count at or beyond its last value is treated as
  // terminal, so any out-of-range state falls back to 0 at the next wrap
  // decision. All flags are decoded from the next position, not the current
  // one. As a result, the flags register on the same edge as the counters and
  // describe exactly the pixel that the counters present.
  always_comb begin
    hWrap  = (hCnt_q >= H_LAST);
    hCnt_d = hWrap ? 10'd0 : hCnt_q + 10'd1;
    vCnt_d = vCnt_q;
    if (hWrap) begin
      vCnt_d = (vCnt_q >= V_LAST) ? 10'd0 : vCnt_q + 10'd1;
    end
    videoOn_d    = (hCnt_d < H_VIS) && (vCnt_d < V_VIS);
    hsync_d      = ((hCnt_d >= HS_FIRST) && (hCnt_d <= HS_LAST)) ? SYNC_ON : SYNC_OFF;
    vsync_d      = ((vCnt_d >= VS_FIRST) && (vCnt_d <= VS_LAST)) ? SYNC_ON : SYNC_OFF;
    lineStart_d  = (hCnt_d == 10'd0);
    frameStart_d = (hCnt_d == 10'd0) && (vCnt_d == 10'd0);
  end

  // Position and flag registers. Reset parks the raster on the last pixel of
  // the frame. That pixel lies in the back porch, so the reset flag values
  // agree with the decode. The first edge after release therefore lands on
  // (0,0) and raises frame_start.
  always_ff @(posedge pixel_clock or posedge rst) begin
    if (rst) begin
      hCnt_q       <= H_LAST;
      vCnt_q       <= V_LAST;
      videoOn_q    <= 1'b0;
      hsync_q      <= SYNC_OFF;
      vsync_q      <= SYNC_OFF;
      lineStart_q  <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      hCnt_q       <= hCnt_d;
      vCnt_q       <= vCnt_d;
      videoOn_q    <= videoOn_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      lineStart_q  <= lineStart_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign hPos        = hCnt_q;
  assign vPos        = vCnt_q;
  assign videoOn     = videoOn_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = lineStart_q;
  assign frame_start = frameStart_q;

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frameCnt_q, frameCnt_d;
  logic        firstSeen_q, firstSeen_d;

  // Frame counter. The first frame_start after reset only arms the counter,
  // so that frame shows 0. Each later frame_start adds one on the same edge
  // that raises frame_start, which keeps the value aligned with the strobe.
  // The count wraps naturally from 0xFFFF to 0x0000.
  always_comb begin
    frameCnt_d  = frameCnt_q;
    firstSeen_d = firstSeen_q;
    if (frameStart_d) begin
      if (firstSeen_q) begin
        frameCnt_d = frameCnt_q + 16'd1;
      end
      firstSeen_d = 1'b1;
    end
  end

  // Frame counter registers, cleared together with the raster.
  always_ff @(posedge pixel_clock or posedge rst) begin
    if (rst) begin
      frameCnt_q  <= 16'd0;
      firstSeen_q <= 1'b0;
    end else begin
      frameCnt_q  <= frameCnt_d;
      firstSeen_q <= firstSeen_d;
    end
  end

  assign frame_count = frameCnt_q;
`else
  assign frame_count = 16'd0;
`endif

endmodule
